ahb_interconnect: RTL

- Parametrised multi-manager, multi-subordinate AHB-Lite shared-bus interconnect for the SoC; successor to the fixed 2x2 processor/BSRAM/APB-bridge bus.
- Adds round-robin arbitration with burst/lock hold, range-based address decode, registered data-phase routing and a built-in default subordinate returning ERROR for unmapped addresses.
- One manager owns the address phase per cycle. Address and data phases are pipelined, so the previous owner's data phase can overlap the new owner's address phase.

---
 rtl/ahb_pkg.sv | 36 +++
 rtl/ahb_rr_arbiter.sv | 40 ++++
 rtl/ahb_interconnect.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ============================================================================
// ahb_pkg: shared AHB-Lite encodings and helpers for the interconnect slice.
// Rev 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

  typedef logic [1:0] htrans_t;
  typedef logic [2:0] hburst_t;

  localparam htrans_t HTRANS_IDLE   = 2'b00;
  localparam htrans_t HTRANS_BUSY   = 2'b01;
  localparam htrans_t HTRANS_NONSEQ = 2'b10;
  localparam htrans_t HTRANS_SEQ    = 2'b11;

  localparam hburst_t HBURST_SINGLE = 3'b000;
  localparam hburst_t HBURST_INCR   = 3'b001;
  localparam hburst_t HBURST_WRAP4  = 3'b010;
  localparam hburst_t HBURST_INCR4  = 3'b011;
  localparam hburst_t HBURST_WRAP8  = 3'b100;
  localparam hburst_t HBURST_INCR8  = 3'b101;
  localparam hburst_t HBURST_WRAP16 = 3'b110;
  localparam hburst_t HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_rr_arbiter.sv
// ============================================================================
// ahb_rr_arbiter: round-robin next-owner selection with hold and park.
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic          hold,
  input  logic          advance,
  input  logic [IW-1:0] cur,
  output logic [IW-1:0] nxt
);

  logic found;

  // Scan starts just after the current owner; offset N revisits the owner itself.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    if (advance && !hold) begin
      for (int off = 1; off <= N; off++) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req[k] && (k == ((int'(cur) + off) % N))) begin
            nxt   = IW'(k);
            found = 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_interconnect.sv
// ============================================================================
// ahb_interconnect: N-manager / M-subordinate AHB-Lite shared bus with default slave.
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_interconnect
  import ahb_pkg::*;
#(
  parameter int N_MANAGERS     = 2,
  parameter int N_SUBORDINATES = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [N_SUBORDINATES*ADDR_WIDTH-1:0] SUB_BASE_ADDRS = {32'h00080000, 32'h00000000},
  parameter logic [N_SUBORDINATES*ADDR_WIDTH-1:0] SUB_END_ADDRS  = {32'h000FFFFF, 32'h0007FFFF}
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_MANAGERS*ADDR_WIDTH-1:0]     m_haddr,
  input  logic [N_MANAGERS*2-1:0]              m_htrans,
  input  logic [N_MANAGERS-1:0]                m_hwrite,
  input  logic [N_MANAGERS*3-1:0]              m_hsize,
  input  logic [N_MANAGERS*3-1:0]              m_hburst,
  input  logic [N_MANAGERS*4-1:0]              m_hprot,
  input  logic [N_MANAGERS-1:0]                m_hmastlock,
  input  logic [N_MANAGERS*DATA_WIDTH-1:0]     m_hwdata,
  output logic [N_MANAGERS*DATA_WIDTH-1:0]     m_hrdata,
  output logic [N_MANAGERS-1:0]                m_hready,
  output logic [N_MANAGERS-1:0]                m_hresp,
  output logic [N_SUBORDINATES-1:0]            s_hsel,
  output logic [ADDR_WIDTH-1:0]                s_haddr,
  output logic [1:0]                           s_htrans,
  output logic                                 s_hwrite,
  output logic [2:0]                           s_hsize,
  output logic [2:0]                           s_hburst,
  output logic [3:0]                           s_hprot,
  output logic                                 s_hmastlock,
  output logic [DATA_WIDTH-1:0]                s_hwdata,
  output logic                                 s_hready,
  input  logic [N_SUBORDINATES-1:0]            s_hreadyout,
  input  logic [N_SUBORDINATES-1:0]            s_hresp,
  input  logic [N_SUBORDINATES*DATA_WIDTH-1:0] s_hrdata,
  output logic [idx_width(N_MANAGERS)-1:0]     hmaster
);

  localparam int IW = idx_width(N_MANAGERS);
  localparam int SW = idx_width(N_SUBORDINATES + 1);
  // The default subordinate sits one past the last real subordinate.
  localparam logic [SW-1:0] DEF_SEL = SW'(N_SUBORDINATES);

  localparam logic [0:0] ERR_IDLE = 1'b0;
  localparam logic [0:0] ERR_ERR1 = 1'b1;

  logic [IW-1:0]         addr_owner;
  logic [IW-1:0]         data_owner;
  logic [SW-1:0]         data_sel;
  logic                  data_active;
  logic [0:0]            err_state;
  logic [0:0]            err_next;

  logic [ADDR_WIDTH-1:0] own_haddr;
  htrans_t               own_htrans;
  logic                  own_hwrite;
  logic [2:0]            own_hsize;
  hburst_t               own_hburst;
  logic [3:0]            own_hprot;
  logic                  own_hmastlock;

  logic [N_MANAGERS-1:0] req;
  logic                  hold;
  logic [IW-1:0]         arb_next;
  logic [SW-1:0]         addr_sel;

  logic                  sel_ready;
  logic                  sel_resp;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  def_ready;
  logic                  def_resp;
  logic                  data_is_def;
  logic                  hready_bus;
  logic                  data_resp;
  logic [DATA_WIDTH-1:0] data_rdata;
  logic [DATA_WIDTH-1:0] data_hwdata;

  always_comb begin
    own_haddr     = '0;
    own_htrans    = HTRANS_IDLE;
    own_hwrite    = 1'b0;
    own_hsize     = '0;
    own_hburst    = HBURST_SINGLE;
    own_hprot     = '0;
    own_hmastlock = 1'b0;
    data_hwdata   = '0;
    for (int k = 0; k < N_MANAGERS; k++) begin
      if (addr_owner == IW'(k)) begin
        own_haddr     = m_haddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        own_htrans    = m_htrans[k*2 +: 2];
        own_hwrite    = m_hwrite[k];
        own_hsize     = m_hsize[k*3 +: 3];
        own_hburst    = m_hburst[k*3 +: 3];
        own_hprot     = m_hprot[k*4 +: 4];
        own_hmastlock = m_hmastlock[k];
      end
      if (data_owner == IW'(k)) begin
        data_hwdata = m_hwdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Descending scan so the lowest matching subordinate wins on overlap.
  always_comb begin
    addr_sel = DEF_SEL;
    for (int j = N_SUBORDINATES - 1; j >= 0; j--) begin
      if ((own_haddr >= SUB_BASE_ADDRS[j*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (own_haddr <= SUB_END_ADDRS[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
        addr_sel = SW'(j);
      end
    end
  end

  always_comb begin
    s_hsel = '0;
    for (int j = 0; j < N_SUBORDINATES; j++) begin
      s_hsel[j] = (own_htrans != HTRANS_IDLE) && (addr_sel == SW'(j));
    end
  end

  always_comb begin
    sel_ready = 1'b1;
    sel_resp  = HRESP_OKAY;
    sel_rdata = '0;
    for (int j = 0; j < N_SUBORDINATES; j++) begin
      if (data_sel == SW'(j)) begin
        sel_ready = s_hreadyout[j];
        sel_resp  = s_hresp[j];
        sel_rdata = s_hrdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign data_is_def = (data_sel == DEF_SEL);

  // Two-cycle ERROR: first cycle stalls, second completes.
  always_comb begin
    def_ready = 1'b1;
    def_resp  = HRESP_OKAY;
    err_next  = ERR_IDLE;
    case (err_state)
      ERR_IDLE: begin
        if (data_active && data_is_def) begin
          def_ready = 1'b0;
          def_resp  = HRESP_ERROR;
          err_next  = ERR_ERR1;
        end
      end
      ERR_ERR1: begin
        def_resp = HRESP_ERROR;
        err_next = ERR_IDLE;
      end
      default: err_next = ERR_IDLE;
    endcase
  end

  always_comb begin
    if (!data_active) begin
      hready_bus = 1'b1;
      data_resp  = HRESP_OKAY;
      data_rdata = '0;
    end else if (data_is_def) begin
      hready_bus = def_ready;
      data_resp  = def_resp;
      data_rdata = '0;
    end else begin
      hready_bus = sel_ready;
      data_resp  = sel_resp;
      data_rdata = sel_rdata;
    end
  end

  assign hold = own_hmastlock ||
                (own_htrans == HTRANS_SEQ) ||
                ((own_htrans == HTRANS_NONSEQ) && (own_hburst != HBURST_SINGLE));

  ahb_rr_arbiter #(
    .N  (N_MANAGERS),
    .IW (IW)
  ) u_arb (
    .req     (req),
    .hold    (hold),
    .advance (hready_bus),
    .cur     (addr_owner),
    .nxt     (arb_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_owner  <= '0;
      data_owner  <= '0;
      data_sel    <= DEF_SEL;
      data_active <= 1'b0;
      err_state   <= ERR_IDLE;
    end else begin
      addr_owner <= arb_next;
      err_state  <= err_next;
      if (hready_bus) begin
        data_owner  <= addr_owner;
        data_sel    <= addr_sel;
        data_active <= own_htrans[1];
      end
    end
  end

  generate
    for (genvar k = 0; k < N_MANAGERS; k++) begin : g_mgr
      assign req[k] = m_htrans[k*2 + 1];
      assign m_hrdata[k*DATA_WIDTH +: DATA_WIDTH] = data_rdata;
      assign m_hresp[k]  = (data_owner == IW'(k)) ? data_resp : HRESP_OKAY;
      // A requesting non-owner is held off until it wins the address phase.
      assign m_hready[k] = (addr_owner == IW'(k)) ? hready_bus : !m_htrans[k*2 + 1];
    end
  endgenerate

  assign s_haddr     = own_haddr;
  assign s_htrans    = own_htrans;
  assign s_hwrite    = own_hwrite;
  assign s_hsize     = own_hsize;
  assign s_hburst    = own_hburst;
  assign s_hprot     = own_hprot;
  assign s_hmastlock = own_hmastlock;
  assign s_hwdata    = data_hwdata;
  assign s_hready    = hready_bus;
  assign hmaster     = addr_owner;

endmodule

`default_nettype wire
